btn_cmd_decoder: RTL and testbench
==================================

Name: btn_cmd_decoder

Overview:
Input-conditioning stage directly upstream of the stack-calculator controller. It synchronises and debounces the four raw push-buttons and detects press edges. It turns each press into exactly one registered command (opcode plus switch operand), held under a valid/ready handshake. This replaces the controller's direct level sampling of btns, which re-triggers every clock while a button is held.

Parameters:
DB_CYCLES, 500000, consecutive stable clk cycles required before a debounced button changes state (5 ms at 100 MHz)
CNT_W, 20, width of each per-button debounce counter; must satisfy 2^CNT_W > DB_CYCLES

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  reset, asynchronous assert, active-low
btns  input  4  raw push-buttons, asynchronous, active-high; [3:2] mode select, [1:0] action triggers
swtchs  input  8  raw slide switches, operand value
cmd_valid  output  1  command pending
cmd_ready  input  1  controller accepts command this cycle
cmd_op  output  3  command opcode
cmd_data  output  8  operand captured with the command
db_btns  output  4  debounced button levels
overrun  output  1  sticky: a press was dropped because a command was still pending

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n). While rst_n=0: all synchroniser flops, counters, db_btns, cmd_valid, cmd_op, cmd_data and overrun are 0, and the FSM is IDLE. Release is sampled on the next rising clk.
- Synchroniser: each btns bit passes through 2 flops (s1, s2). swtchs also passes through 2 flops. Switches are not debounced.
- Debounce, per bit i:
  - If s2[i]==db_btns[i], cnt[i] <= 0.
  - Otherwise cnt[i] increments. When cnt[i]==DB_CYCLES-1 and the bit still differs, db_btns[i] flips and cnt[i] <= 0.
  - A raw level held stable appears on db_btns on the (2+DB_CYCLES)th rising edge after the change.
  - Any glitch shorter than DB_CYCLES cycles produces no change on db_btns.
- Edge detect: prev_db <= db_btns each cycle. press[i] = db_btns[i] & ~prev_db[i]. Releases generate nothing. Edges on bits [3:2] generate nothing.
- Trigger: trig = press[0] | press[1]. If both press in the same cycle, btn1 wins (sel=1). Otherwise sel = press[1].
- Opcode: cmd_op = {db_btns[3:2], sel}, with db_btns[3:2] sampled in the trigger cycle.
  - 000 push, 001 pop, 010 add, 011 sub
  - 100 top, 101 clear, 110 dec_addr, 111 inc_addr
- cmd_data = synchronised swtchs, captured in the trigger cycle.
- FSM:
  - IDLE: on trig, load cmd_op and cmd_data, set cmd_valid=1, go to PENDING. The command is visible on the edge after the press is detected, i.e. 3+DB_CYCLES edges after the raw press.
  - PENDING: cmd_valid, cmd_op and cmd_data are held stable. A transfer occurs on the rising edge where cmd_valid & cmd_ready.
    - Transfer with no trig that cycle: cmd_valid <= 0, go to IDLE.
    - Transfer with trig in the same cycle: load the new command, stay PENDING, cmd_valid stays 1. No bubble, no drop.
    - trig without a transfer: the press is dropped, overrun <= 1, and the held command is unchanged.
- overrun clears only on reset.
- cmd_ready while cmd_valid=0 is ignored.
- Counters never wrap: the cnt reset at DB_CYCLES-1 bounds them.

Test Plan:
1. DB_CYCLES=4. Set btns[3:2]=00, swtchs=0x2A, then pulse btns[0] high for 20 cycles with cmd_ready=0 -> exactly one cmd_valid rise, 7 edges after the raw rise. cmd_op=000, cmd_data=0x2A, held until cmd_ready=1. Then cmd_valid=0 the next edge and no second command while the button stays held.
2. Bounce: toggle btns[1] every 2 cycles for 30 cycles, then hold 0 -> db_btns[1] never changes, cmd_valid stays 0.
3. Set btns[3:2]=11, press btns[1] and btns[0] in the same cycle -> a single command with cmd_op=111.
4. With a command pending and cmd_ready=0, press btns[0] again -> the original cmd_op/cmd_data are unchanged and overrun=1. It stays 1 after acceptance until rst_n=0.
5. Hold cmd_ready=1 so the transfer coincides with a new press (btns[3:2]=01, btns[1], swtchs=0x05) -> cmd_valid stays 1 across the edge, cmd_op=011, cmd_data=0x05, overrun=0.
6. Assert rst_n=0 asynchronously mid-debounce and while PENDING -> all outputs are 0 immediately, with no clock edge. After release, the still-held button produces one command once it is debounced again.

Source files
------------

// File: rtl/btn_cmd_decoder.sv
// Push-button front end for the stack-calculator controller: sync, debounce,
// press-edge detect, and one registered command per press under valid/ready.

module btn_cmd_decoder_db #(
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_i,
  output logic db_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             db_q;

  // Any sample that agrees with the debounced level restarts the stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else if (sync_i == db_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q <= '0;
      db_q  <= ~db_q;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign db_o = db_q;
endmodule

module btn_cmd_decoder #(
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btns,
  input  logic [7:0] swtchs,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [2:0] cmd_op,
  output logic [7:0] cmd_data,
  output logic [3:0] db_btns,
  output logic       overrun
);
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_PEND = 1'b1;

  logic [3:0] s1_q, s2_q, prev_q, press;
  logic [7:0] sw1_q, sw2_q;
  logic       state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [7:0] data_q, data_d;
  logic       ovr_q, ovr_d;
  logic       trig, sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      sw1_q  <= '0;
      sw2_q  <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= btns;
      s2_q   <= s1_q;
      sw1_q  <= swtchs;
      sw2_q  <= sw1_q;
      prev_q <= db_btns;
    end
  end

  btn_cmd_decoder_db #(
    .DB_CYCLES(DB_CYCLES),
    .CNT_W    (CNT_W)
  ) u_db [3:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .sync_i(s2_q),
    .db_o  (db_btns)
  );

  // Only the action buttons generate commands; btn1 wins a simultaneous press.
  assign press = db_btns & ~prev_q;
  assign trig  = press[0] | press[1];
  assign sel   = press[1];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d = ST_PEND;
          op_d    = {db_btns[3:2], sel};
          data_d  = sw2_q;
        end
      end
      default: begin
        if (cmd_ready) begin
          if (trig) begin
            op_d   = {db_btns[3:2], sel};
            data_d = sw2_q;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (trig) begin
          ovr_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

  assign cmd_valid = (state_q == ST_PEND);
  assign cmd_op    = op_q;
  assign cmd_data  = data_q;
  assign overrun   = ovr_q;
endmodule

// File: tb/tb_btn_cmd_decoder.sv
// Bench for btn_cmd_decoder: directed scenarios plus random button/ready traffic,
// with a window-based reference model feeding a command scoreboard.

module tb_btn_cmd_decoder;
  localparam int DB = 4;

  logic       clk, rst_n, cmd_valid, cmd_ready, overrun;
  logic [3:0] btns, db_btns;
  logic [7:0] swtchs, cmd_data;
  logic [2:0] cmd_op;

  int checks = 0;
  int errors = 0;

  btn_cmd_decoder #(.DB_CYCLES(DB), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .btns(btns), .swtchs(swtchs),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .db_btns(db_btns), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
  } cmd_t;

  cmd_t       expq[$];
  logic [3:0] rh[$];
  logic [7:0] sh[$];
  logic [3:0] mdb, mprev;
  logic       mvalid, movr;
  logic [2:0] mop;
  logic [7:0] mdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mreset();
    rh.delete();
    sh.delete();
    for (int i = 0; i < DB + 2; i++) begin
      rh.push_back(4'h0);
      sh.push_back(8'h00);
    end
    mdb = '0; mprev = '0; mvalid = 1'b0; movr = 1'b0; mop = '0; mdata = '0;
    expq.delete();
  endtask

  // rh/sh hold raw samples; the last entry is the previous edge's sample, so
  // the synchronised value seen at this edge is the one before it.
  task automatic mstep();
    logic [3:0] press, ndb;
    logic       trig, alld;
    cmd_t       c;
    press = mdb & ~mprev;
    trig  = press[0] | press[1];
    if (!mvalid || cmd_ready) begin
      if (trig) begin
        mop    = {mdb[3:2], press[1]};
        mdata  = sh[sh.size()-2];
        mvalid = 1'b1;
        c.op = mop; c.data = mdata;
        expq.push_back(c);
      end else begin
        mvalid = 1'b0;
      end
    end else if (trig) begin
      movr = 1'b1;
    end
    // A bit flips once its last DB synchronised samples all disagree with it.
    for (int b = 0; b < 4; b++) begin
      alld = 1'b1;
      for (int j = 0; j < DB; j++)
        if (rh[rh.size()-2-j][b] == mdb[b]) alld = 1'b0;
      ndb[b] = alld ? ~mdb[b] : mdb[b];
    end
    mprev = mdb;
    mdb   = ndb;
    rh.push_back(btns);
    sh.push_back(swtchs);
    while (rh.size() > DB + 2) begin
      void'(rh.pop_front());
      void'(sh.pop_front());
    end
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) mreset();
      else mstep();
    end
  end

  // Monitor: inputs change at posedge+2, so negedge values are what the next edge sees.
  initial begin
    cmd_t c;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("valid", cmd_valid, mvalid);
        chk("db_btns", db_btns, mdb);
        chk("overrun", overrun, movr);
        if (mvalid) begin
          chk("held_op", cmd_op, mop);
          chk("held_data", cmd_data, mdata);
        end
        if (cmd_valid && cmd_ready) begin
          if (expq.size() == 0) begin
            chk("sb_unexpected_xfer", 1, 0);
          end else begin
            c = expq.pop_front();
            chk("sb_op", cmd_op, c.op);
            chk("sb_data", cmd_data, c.data);
          end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int first;
    int hold[4];
    rst_n = 1'b0; btns = '0; swtchs = '0; cmd_ready = 1'b0;
    tick(3);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_outs", {cmd_op, cmd_data, db_btns, overrun}, 0);
    rst_n = 1'b1;
    tick(6);

    // single press, command held until accepted, no repeat while held
    swtchs = 8'h2A;
    tick(2);
    btns[0] = 1'b1;
    first = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (cmd_valid && first == 0) first = n;
    end
    chk("t1_latency", first, 7);
    chk("t1_op", cmd_op, 3'b000);
    chk("t1_data", cmd_data, 8'h2A);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("t1_accept", cmd_valid, 0);
    tick(10);
    chk("t1_no_repeat", cmd_valid, 0);
    btns[0] = 1'b0;
    tick(8);

    // bounce shorter than the debounce window
    for (int i = 0; i < 15; i++) begin
      btns[1] = ~btns[1];
      tick(2);
    end
    btns[1] = 1'b0;
    tick(8);
    chk("t2_db1", db_btns[1], 0);
    chk("t2_valid", cmd_valid, 0);

    // simultaneous press, btn1 wins
    btns = 4'b1100;
    tick(8);
    btns = 4'b1111; swtchs = 8'h33;
    tick(8);
    chk("t3_valid", cmd_valid, 1);
    chk("t3_op", cmd_op, 3'b111);
    chk("t3_data", cmd_data, 8'h33);

    // press while pending is dropped
    btns = 4'b1100;
    tick(8);
    btns = 4'b1101; swtchs = 8'h44;
    tick(8);
    chk("t4_op", cmd_op, 3'b111);
    chk("t4_data", cmd_data, 8'h33);
    chk("t4_overrun", overrun, 1);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("t4_accept", cmd_valid, 0);
    chk("t4_sticky", overrun, 1);
    btns = 4'b0000;
    tick(8);
    chk("t4_sticky2", overrun, 1);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_ovr", overrun, 0);
    tick();
    rst_n = 1'b1;
    tick(6);

    // back-to-back: transfer coincides with a new press
    btns = 4'b0100;
    tick(8);
    cmd_ready = 1'b1;
    swtchs = 8'h11;
    btns[0] = 1'b1;
    tick();
    btns[1] = 1'b1; swtchs = 8'h05;
    tick(6);
    chk("t5_first_valid", cmd_valid, 1);
    chk("t5_first_op", cmd_op, 3'b010);
    tick();
    chk("t5_valid", cmd_valid, 1);
    chk("t5_op", cmd_op, 3'b011);
    chk("t5_data", cmd_data, 8'h05);
    chk("t5_ovr", overrun, 0);
    tick();
    chk("t5_drain", cmd_valid, 0);
    cmd_ready = 1'b0; btns = 4'b0000;
    tick(8);

    // async reset mid-debounce, then while pending
    btns = 4'b0001; swtchs = 8'h77;
    tick(3);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_db", {cmd_valid, cmd_op, cmd_data, db_btns, overrun}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    chk("t6_cmd_valid", cmd_valid, 1);
    chk("t6_cmd", {cmd_op, cmd_data}, {3'b000, 8'h77});
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_pend", {cmd_valid, cmd_op, cmd_data, db_btns, overrun}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    chk("t6_again", cmd_valid, 1);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    tick(10);
    chk("t6_once", cmd_valid, 0);
    btns = 4'b0000;
    tick(8);

    // random traffic
    for (int b = 0; b < 4; b++) hold[b] = $urandom_range(1, 12);
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++) begin
        hold[b]--;
        if (hold[b] <= 0) begin
          btns[b] = ~btns[b];
          hold[b] = $urandom_range(1, 12);
        end
      end
      swtchs    = 8'($urandom);
      cmd_ready = ($urandom_range(0, 3) == 0);
      tick();
    end

    btns = 4'b0000; cmd_ready = 1'b1;
    tick(20);
    chk("sb_drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
